serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 150 +++++++++++++++
 tb/tb_serial_adder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial two's-complement adder/subtractor. One full-adder stage
//   processes one bit per clock, LSB first, so a WIDTH-bit operation
//   takes WIDTH cycles in RUN followed by a single DONE cycle.
//
// Ports
//   clk       in   clock, rising-edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin an operation (accepted in IDLE or DONE)
//   a, b      in   operands, sampled only on acceptance
//   sub       in   0 = a+b, 1 = a-b, sampled only on acceptance
//   busy      out  high while bits are being processed
//   done      out  one-cycle pulse, result and flags valid
//   result    out  sum or difference (modulo 2^WIDTH)
//   cout      out  carry out of the MSB (for subtraction: no borrow)
//   overflow  out  signed overflow
//   zero      out  result == 0
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// RUN   | shifting one bit per cycle through the full adder
// DONE  | result valid for one cycle; start here chains a new op

module serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic             cmsb;
  logic [CW-1:0]    cnt;
  logic             cout_r;
  logic             zero_r;

  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] result_nxt;

  // single full-adder stage on the current LSBs
  assign sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_nxt  = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign result_nxt = {sum_bit, result[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last_bit  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      cmsb   <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout_r <= 1'b0;
      zero_r <= 1'b1;
    end else if (accept) begin
      a_sh  <= a;
      // subtraction is a + ~b + 1; the +1 enters as the initial carry
      b_sh  <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= carry_nxt;
      cnt    <= cnt + 1'b1;
      result <= result_nxt;
      // flags are captured only on the final bit so they change with done
      // and stay stable through IDLE, unaffected by a later accept
      if (last_bit) begin
        cmsb   <= carry;
        cout_r <= carry_nxt;
        zero_r <= (result_nxt == '0);
      end
    end
  end

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign cout     = cout_r;
  assign overflow = cmsb ^ cout_r;
  assign zero     = zero_r;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Scoreboard bench for serial_adder at WIDTH=32. Expected results are
//   computed from a wide integer add and pushed when an op is started;
//   they are popped and compared when done is observed.

module tb_serial_adder;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         zero;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         ovf;
    logic         z;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic ts);
    exp_t         e;
    logic [W:0]   s;
    logic [W-1:0] bb;
    bb    = ts ? ~tb : tb;
    s     = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, ts};
    e.res = s[W-1:0];
    e.c   = s[W];
    e.ovf = (ta[W-1] == bb[W-1]) && (s[W-1] != ta[W-1]);
    e.z   = (s[W-1:0] == '0);
    return e;
  endfunction

  // Presents an op at the falling edge, lets the next rising edge accept it,
  // then scrambles the operand inputs to show they are not resampled.
  task automatic drive_start(input logic [W-1:0] ta, input logic [W-1:0] tb,
                             input logic ts);
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb;
    sub   = ts;
    exp_q.push_back(model(ta, tb, ts));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    sub   = 1'($urandom_range(0, 1));
  endtask

  // Called #1 after the accepting edge. Counts edges until done and busy
  // samples along the way; a start with other operands may be injected
  // at edge number pulse_at (0 = never).
  task automatic wait_done(input string name, input int pulse_at,
                           output int lat, output int busy_n);
    bit got;
    got    = 0;
    lat    = 0;
    busy_n = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      if (busy) busy_n++;
      if (i == pulse_at) begin
        start = 1'b1;
        a     = 32'h1234_5678;
        b     = 32'h0000_0001;
        sub   = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = i;
        got = 1;
      end
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s timeout: no done within 40 edges", name);
    end
  endtask

  task automatic check_outputs(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s scoreboard empty when done observed", name);
      return;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (result !== e.res) begin
      n_bad++;
      $display("FAIL %s result got %h want %h", name, result, e.res);
    end
    n_cmp++;
    if (cout !== e.c) begin
      n_bad++;
      $display("FAIL %s cout got %b want %b", name, cout, e.c);
    end
    n_cmp++;
    if (overflow !== e.ovf) begin
      n_bad++;
      $display("FAIL %s overflow got %b want %b", name, overflow, e.ovf);
    end
    n_cmp++;
    if (zero !== e.z) begin
      n_bad++;
      $display("FAIL %s zero got %b want %b", name, zero, e.z);
    end
  endtask

  task automatic check_lat(input string name, input int lat, input int want);
    n_cmp++;
    if (lat !== want) begin
      n_bad++;
      $display("FAIL %s latency got %0d want %0d", name, lat, want);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ta,
                        input logic [W-1:0] tb, input logic ts);
    int lat;
    int bn;
    drive_start(ta, tb, ts);
    wait_done(name, 0, lat, bn);
    check_lat(name, lat, W);
    check_outputs(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    sub   = 1'b0;
    #23;
    n_cmp++;
    if ({busy, done, cout, overflow, zero} !== 5'b00001 || result !== '0) begin
      n_bad++;
      $display("FAIL reset_state busy/done/cout/ovf/zero got %b result %h want 00001 result 0",
               {busy, done, cout, overflow, zero}, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_basic();
    int lat;
    int bn;
    drive_start(32'd5, 32'd3, 1'b0);
    wait_done("add_5_3", 0, lat, bn);
    check_lat("add_5_3", lat, W);
    n_cmp++;
    if (bn !== W) begin
      n_bad++;
      $display("FAIL add_5_3 busy cycles got %0d want %0d", bn, W);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL add_5_3 busy in done got %b want 0", busy);
    end
    check_outputs("add_5_3");
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL done_pulse_width done got %b want 0", done);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (result !== 32'd8 || zero !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_in_idle result got %h zero %b want 00000008 zero 0", result, zero);
    end
  endtask

  task automatic test_boundaries();
    run_op("wrap_ffffffff_plus_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("ovf_7fffffff_plus_1", 32'h7FFF_FFFF, 32'd1, 1'b0);
    run_op("sub_5_minus_7", 32'd5, 32'd7, 1'b1);
    run_op("sub_neg_ovf", 32'h8000_0000, 32'd1, 1'b1);
    run_op("sub_equal", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
  endtask

  task automatic test_restart_ignored();
    int lat;
    int bn;
    drive_start(32'h0001_0000, 32'h0000_0FFF, 1'b0);
    wait_done("restart_ignored", 10, lat, bn);
    check_lat("restart_ignored", lat, W);
    check_outputs("restart_ignored");
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int bn;
    bit saw_done;
    drive_start(32'h0F0F_0F0F, 32'h1111_1111, 1'b0);
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, cout, overflow, zero} !== 5'b00001 || result !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_run busy/done/cout/ovf/zero got %b result %h want 00001 result 0",
               {busy, done, cout, overflow, zero}, result);
    end
    void'(exp_q.pop_front());
    saw_done = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1;
    end
    n_cmp++;
    if (saw_done) begin
      n_bad++;
      $display("FAIL reset_mid_run done pulse got 1 want 0");
    end
    #1;
    rst_n = 1'b0;
    #2;
    // release away from any edge; the very next rising edge must accept
    rst_n = 1'b1;
    drive_start(32'd2, 32'd2, 1'b0);
    wait_done("after_reset_2_plus_2", 0, lat, bn);
    check_lat("after_reset_2_plus_2", lat, W);
    check_outputs("after_reset_2_plus_2");
  endtask

  task automatic test_back_to_back();
    int lat;
    int bn;
    drive_start(32'd100, 32'd23, 1'b0);
    wait_done("b2b_first", 0, lat, bn);
    check_lat("b2b_first", lat, W);
    check_outputs("b2b_first");
    // still in the DONE cycle here
    drive_start(32'd10, 32'd4, 1'b1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_no_idle busy got %b want 1", busy);
    end
    wait_done("b2b_10_minus_4", 0, lat, bn);
    check_lat("b2b_10_minus_4", lat, W);
    check_outputs("b2b_10_minus_4");
  endtask

  task automatic test_random();
    logic [W-1:0] ta;
    logic [W-1:0] tb;
    logic         ts;
    for (int i = 0; i < 8; i++) begin
      ta = $urandom;
      tb = $urandom;
      ts = 1'($urandom_range(0, 1));
      run_op("random", ta, tb, ts);
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_boundaries();
    test_restart_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain leftover got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
